// File: rtl/lfsr_checker.sv
// Lock/verify checker for a 4-bit LFSR stream (x^4 + x^3 + 1, period 15).
// Build option LFSR_CHK_SELF_SYNC_EN: on a LOCKED mismatch, resync the reference to the received value.
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    // state  | meaning
    // SEARCH | waiting for a nonzero sample to seed the reference
    // VERIFY | counting consecutive matches toward LOCK_CNT
    // LOCKED | tracking the stream, counting errors and misses
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t           r_state, w_state_nx;
    logic [3:0]       r_exp, w_exp_nx;
    logic [3:0]       r_good, w_good_nx;
    logic [3:0]       r_miss, w_miss_nx;
    logic             r_err, w_err_nx;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nx;

    logic             w_match;
    logic             w_zero;
    logic [3:0]       w_good_inc;
    logic [3:0]       w_miss_inc;

    function automatic logic [3:0] lfsr_next(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    assign w_match    = (in_data == r_exp);
    assign w_zero     = (in_data == 4'b0000);
    assign w_good_inc = r_good + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_exp     <= 4'b0000;
            r_good    <= 4'd0;
            r_miss    <= 4'd0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_exp     <= w_exp_nx;
            r_good    <= w_good_nx;
            r_miss    <= w_miss_nx;
            r_err     <= w_err_nx;
            r_err_cnt <= w_err_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_exp_nx     = r_exp;
        w_good_nx    = r_good;
        w_miss_nx    = r_miss;
        w_err_nx     = 1'b0;
        w_err_cnt_nx = r_err_cnt;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    if (!w_zero) begin
                        w_exp_nx   = lfsr_next(in_data);
                        w_good_nx  = 4'd1;
                        w_state_nx = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_match) begin
                        w_good_nx = w_good_inc;
                        w_exp_nx  = lfsr_next(r_exp);
                        if (w_good_inc == 4'(LOCK_CNT)) begin
                            w_state_nx = LOCKED;
                            w_miss_nx  = 4'd0;
                        end
                    end else if (!w_zero) begin
                        w_exp_nx  = lfsr_next(in_data);
                        w_good_nx = 4'd1;
                    end else begin
                        w_state_nx = SEARCH;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_miss_nx = 4'd0;
                        w_exp_nx  = lfsr_next(r_exp);
                    end else begin
                        w_err_nx  = 1'b1;
                        w_miss_nx = w_miss_inc;
                        if (r_err_cnt != {ERR_W{1'b1}})
                            w_err_cnt_nx = r_err_cnt + ERR_W'(1);
`ifdef LFSR_CHK_SELF_SYNC_EN
                        w_exp_nx = w_zero ? lfsr_next(r_exp) : lfsr_next(in_data);
`else
                        w_exp_nx = lfsr_next(r_exp);
`endif
                        if (w_miss_inc == 4'(MISS_MAX))
                            w_state_nx = SEARCH;
                    end
                end
                default: w_state_nx = SEARCH;
            endcase
        end
    end

    assign locked  = (r_state == LOCKED);
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correct samples needed to lock; range 2..15.
REQ-002 Parameter MISS_MAX, default 3: consecutive mismatches in LOCKED that drop lock; range 1..15.
REQ-003 Parameter ERR_W, default 8: err_cnt width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset: 0 resets immediately, released synchronously to clk.
REQ-006 in_valid  input  1  in_data is a sample this cycle.
REQ-007 in_data  input  4  received LFSR value.
REQ-008 locked  output  1  checker is in LOCKED state.
REQ-009 err  output  1  one-cycle pulse, mismatch detected while LOCKED.
REQ-010 err_cnt  output  ERR_W  saturating count of mismatches detected while LOCKED.

Function
REQ-011 Sequence SHALL be next(x) = {x[2:0], x[3]^x[2]}; period 15; value 0000 is illegal. From 0001: 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001.
REQ-012 Internal state: expected value exp[3:0], good counter, miss counter, FSM with states SEARCH, VERIFY, LOCKED.
REQ-013 Cycles with in_valid=0 SHALL change no state and no output except err returning to 0.
REQ-014 SEARCH: a valid nonzero sample s -> exp=next(s), good=1, go VERIFY; a valid 0000 -> remain SEARCH.
REQ-015 VERIFY: valid sample == exp -> good+1, exp=next(exp); when good+1 == LOCK_CNT -> go LOCKED, miss=0.
REQ-016 VERIFY: valid mismatch with s!=0 -> reseed exp=next(s), good=1, stay VERIFY; mismatch with s==0 -> go SEARCH.
REQ-017 LOCKED: valid sample == exp -> miss=0, exp=next(exp).
REQ-018 LOCKED: valid mismatch (including 0000) -> err=1 next cycle, err_cnt+1 saturating at all-ones, miss+1, exp advanced per REQ-027.
REQ-019 LOCKED: when miss+1 == MISS_MAX on a mismatch -> go SEARCH; err and err_cnt still update for that sample.
REQ-020 Latency: locked, err, err_cnt reflect a sample on the clock edge that captures it (registered outputs, one cycle after in_valid is presented).
REQ-021 locked SHALL equal (state==LOCKED); it deasserts on the edge that leaves LOCKED.
REQ-022 err_cnt is never cleared except by reset; it persists across loss and reacquisition of lock.

Reset
REQ-023 reset=0 SHALL asynchronously force state=SEARCH, exp=0000, good=0, miss=0, locked=0, err=0, err_cnt=0.
REQ-024 reset asserted mid-sequence SHALL discard all progress; after release the checker restarts in SEARCH on the next valid sample.
REQ-025 Samples presented while reset=0 SHALL be ignored.

Configuration
REQ-026 Macro LFSR_CHK_SELF_SYNC_EN selects LOCKED-state mismatch recovery.
REQ-027 Defined: on a LOCKED mismatch with s!=0, exp=next(s) (resync to received stream); s==0 -> exp=next(exp). Undefined: on any LOCKED mismatch, exp=next(exp) (free-running reference).
REQ-028 All other behaviour SHALL be identical in both builds.

Verification
REQ-029 Reset then valid stream 0001,0010,0100,1001 (LOCK_CNT=4) -> locked=1 after fourth sample; err=0, err_cnt=0 throughout.
REQ-030 Locked; inject 0000 in place of 0011 once, then correct stream -> single err pulse, err_cnt=1, locked stays 1 (MISS_MAX=3).
REQ-031 Locked; three consecutive wrong samples -> err pulses 3 times, err_cnt=3, locked=0 on third; correct stream relocks after 4 samples, err_cnt stays 3.
REQ-032 Locked; stream slips by one (0110 skipped) -> with LFSR_CHK_SELF_SYNC_EN: one err, then no more errors; without: err on every subsequent sample until lock lost at MISS_MAX.
REQ-033 Gaps: in_valid toggled 1,0,0,1 over a correct stream -> lock reached after 4 valid samples, no err.
REQ-034 reset pulsed low mid-LOCKED with err_cnt=5 -> locked=0, err_cnt=0 immediately (no clock edge needed); ERR_W=2 run with 5 errors -> err_cnt saturates at 3.
